// File: rtl/audio_pkg.sv
// Shared widths, sample/level types and gain FSM encoding for the envelope VCA.
package audio_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned LEVEL_W  = 8;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic        [LEVEL_W-1:0]  level_t;

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        TRACK
    } gain_state_t;

endpackage

// File: rtl/envelope_vca_if.sv
// Sample stream handshake: source-side and sink-side valid/ready pairs.
interface envelope_vca_if;
    import audio_pkg::*;

    logic    in_valid;
    logic    in_ready;
    sample_t in_sample;
    logic    out_valid;
    logic    out_ready;
    sample_t out_sample;

    modport master (
        output in_valid, in_sample, out_ready,
        input  in_ready, out_valid, out_sample
    );

    modport slave (
        input  in_valid, in_sample, out_ready,
        output in_ready, out_valid, out_sample
    );

endinterface

// File: rtl/envelope_vca_gain_slew.sv
// Slew-limited gain register tracking the envelope level, plus the IDLE/RAMP/TRACK state.
module gain_slew
    import audio_pkg::*;
#(
    parameter int unsigned SLEW_STEP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step_en,
    input  level_t      level,
    output level_t      gain,
    output gain_state_t state
);

    localparam logic signed [LEVEL_W:0] STEP = (LEVEL_W+1)'(SLEW_STEP);

    logic signed [LEVEL_W:0] diff;
    level_t                  gain_nxt;
    gain_state_t             state_nxt;

    always_comb begin
        diff     = $signed({1'b0, level}) - $signed({1'b0, gain});
        gain_nxt = gain;
        if (step_en) begin
            // Snap to level when within one step so the ramp never overshoots or wraps.
            if ((diff <= STEP) && (diff >= -STEP)) begin
                gain_nxt = level;
            end else if (!diff[LEVEL_W]) begin
                gain_nxt = gain + LEVEL_W'(SLEW_STEP);
            end else begin
                gain_nxt = gain - LEVEL_W'(SLEW_STEP);
            end
        end
    end

    always_comb begin
        state_nxt = RAMP;
        if (gain_nxt == level) begin
            state_nxt = (gain_nxt == '0) ? IDLE : TRACK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gain  <= '0;
            state <= IDLE;
        end else begin
            gain  <= gain_nxt;
            state <= state_nxt;
        end
    end

endmodule

// File: rtl/envelope_vca.sv
// Envelope-controlled amplifier: slewed gain applied to a signed sample stream
// through a two-stage valid/ready pipeline with unity and mute bypass.
module envelope_vca
    import audio_pkg::*;
#(
    parameter int unsigned SLEW_STEP = 4
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  level_t               level,
    envelope_vca_if.slave        bus,
    output logic                 active
);

    localparam int unsigned PROD_W = SAMPLE_W + LEVEL_W + 1;

    logic                     en;
    logic                     accept;
    logic                     s1_valid;
    sample_t                  s1_sample;
    level_t                   s1_gain;
    logic                     s2_valid;
    sample_t                  s2_sample;
    logic signed [PROD_W-1:0] prod;
    sample_t                  result;
    level_t                   gain;
    gain_state_t              state;

    assign en     = !s2_valid || bus.out_ready;
    assign accept = bus.in_valid && en;

    assign bus.in_ready   = en;
    assign bus.out_valid  = s2_valid;
    assign bus.out_sample = s2_sample;
    assign active         = (state != IDLE);

    gain_slew #(
        .SLEW_STEP (SLEW_STEP)
    ) u_slew (
        .clk     (sys_clk),
        .rst_n   (sys_rst_n),
        .step_en (accept),
        .level   (level),
        .gain    (gain),
        .state   (state)
    );

    always_comb begin
        prod = PROD_W'(s1_sample) * PROD_W'($signed({1'b0, s1_gain}));
        if (s1_gain == '1) begin
            result = s1_sample;
        end else if (s1_gain == '0) begin
            result = '0;
        end else begin
            // Round half up, then arithmetic shift; |result| <= 32640 so truncation is exact.
            result = sample_t'((prod + PROD_W'(128)) >>> 8);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_valid  <= 1'b0;
            s1_sample <= '0;
            s1_gain   <= '0;
            s2_valid  <= 1'b0;
            s2_sample <= '0;
        end else if (en) begin
            s1_valid  <= accept;
            s1_sample <= bus.in_sample;
            s1_gain   <= gain;
            s2_valid  <= s1_valid;
            s2_sample <= result;
        end
    end

endmodule
